// File: rtl/xil_mem_dp_param_pkg.sv
// Shared types for the parametrised dual-port RAM and its clear sequencer.
package xil_mem_dp_param_pkg;

    typedef enum logic {
        ST_CLR = 1'b0,
        ST_RDY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/xil_mem_clr_fsm.sv
// Post-reset clear sequencer: walks every address once, then reports ready.
module xil_mem_clr_fsm
    import xil_mem_dp_param_pkg::*;
#(
    parameter int unsigned ADR_W         = 9,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             clr_we,
    output logic [ADR_W-1:0] clr_adr,
    output logic             ready
);

    localparam clr_state_e ST_START = INIT_ON_RESET ? ST_CLR : ST_RDY;

    clr_state_e       state;
    clr_state_e       state_nxt;
    logic [ADR_W-1:0] adr_nxt;
    logic             clr_we_nxt;
    logic             ready_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_START;
            clr_adr <= '0;
            clr_we  <= INIT_ON_RESET;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_adr <= adr_nxt;
            clr_we  <= clr_we_nxt;
            ready   <= ready_nxt;
        end
    end

    // Last address is all-ones; the counter returns to zero as the sequence ends.
    always_comb begin
        state_nxt  = state;
        adr_nxt    = clr_adr;
        clr_we_nxt = 1'b0;
        ready_nxt  = 1'b0;
        case (state)
            ST_CLR: begin
                adr_nxt = clr_adr + ADR_W'(1);
                if (&clr_adr) begin
                    state_nxt = ST_RDY;
                end
            end
            ST_RDY:  state_nxt = ST_RDY;
            default: state_nxt = ST_RDY;
        endcase
        clr_we_nxt = (state_nxt == ST_CLR);
        ready_nxt  = (state_nxt == ST_RDY);
    end

endmodule

// File: rtl/xil_mem_dp_param.sv
// Single-clock true dual-port RAM with byte enables, write-first reads,
// deterministic same-address collision merge and a post-reset clear.
module xil_mem_dp_param
    import xil_mem_dp_param_pkg::*;
#(
    parameter int unsigned       ADR_W         = 9,
    parameter int unsigned       BYTES         = 4,
    parameter int unsigned       BYTE_W        = 9,
    parameter bit                OUT_REG       = 1'b0,
    parameter bit                INIT_ON_RESET = 1'b1,
    parameter logic [BYTE_W-1:0] INIT_VAL      = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    o_ready,
    input  logic                    i_en0,
    input  logic [BYTES-1:0]        i_wen0,
    input  logic [ADR_W-1:0]        i_adr0,
    input  logic [BYTES*BYTE_W-1:0] i_wdata0,
    output logic [BYTES*BYTE_W-1:0] o_rdata0,
    output logic                    o_rvalid0,
    input  logic                    i_en1,
    input  logic [BYTES-1:0]        i_wen1,
    input  logic [ADR_W-1:0]        i_adr1,
    input  logic [BYTES*BYTE_W-1:0] i_wdata1,
    output logic [BYTES*BYTE_W-1:0] o_rdata1,
    output logic                    o_rvalid1
);

    localparam int unsigned W     = BYTES * BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADR_W;

    logic             clr_we;
    logic [ADR_W-1:0] clr_adr;
    logic             ready;

    xil_mem_clr_fsm #(
        .ADR_W         (ADR_W),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_we  (clr_we),
        .clr_adr (clr_adr),
        .ready   (ready)
    );

    assign o_ready = ready;

    logic [W-1:0]     mem [DEPTH];
    logic             acc0;
    logic             acc1;
    logic             coll;
    logic [BYTES-1:0] we0;
    logic [BYTES-1:0] we1;
    logic [W-1:0]     word0;
    logic [W-1:0]     word1;

    assign acc0 = ready & i_en0;
    assign acc1 = ready & i_en1;
    assign we0  = acc0 ? i_wen0 : '0;
    assign we1  = acc1 ? i_wen1 : '0;
    assign coll = acc0 & acc1 & (i_adr0 == i_adr1);

    // Post-write word per port; on a collision port 0 wins shared lanes and both see the merge.
    always_comb begin
        word0 = mem[i_adr0];
        word1 = mem[i_adr1];
        for (int k = 0; k < int'(BYTES); k++) begin
            if (we0[k]) begin
                word0[k*BYTE_W +: BYTE_W] = i_wdata0[k*BYTE_W +: BYTE_W];
            end else if (coll && we1[k]) begin
                word0[k*BYTE_W +: BYTE_W] = i_wdata1[k*BYTE_W +: BYTE_W];
            end
            if (coll && we0[k]) begin
                word1[k*BYTE_W +: BYTE_W] = i_wdata0[k*BYTE_W +: BYTE_W];
            end else if (we1[k]) begin
                word1[k*BYTE_W +: BYTE_W] = i_wdata1[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // A collision is committed once through port 0, which already carries the merged word.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_adr] <= {BYTES{INIT_VAL}};
        end else begin
            if ((|we0) || (coll && (|we1))) begin
                mem[i_adr0] <= word0;
            end
            if ((|we1) && !coll) begin
                mem[i_adr1] <= word1;
            end
        end
    end

    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic         rv0;
    logic         rv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0 <= '0;
            rd1 <= '0;
            rv0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= acc0;
            rv1 <= acc1;
            if (acc0) rd0 <= word0;
            if (acc1) rd1 <= word1;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [W-1:0] rd0_q;
        logic [W-1:0] rd1_q;
        logic         rv0_q;
        logic         rv1_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd0_q <= '0;
                rd1_q <= '0;
                rv0_q <= 1'b0;
                rv1_q <= 1'b0;
            end else begin
                rv0_q <= rv0;
                rv1_q <= rv1;
                if (rv0) rd0_q <= rd0;
                if (rv1) rd1_q <= rd1;
            end
        end

        assign o_rdata0  = rd0_q;
        assign o_rdata1  = rd1_q;
        assign o_rvalid0 = rv0_q;
        assign o_rvalid1 = rv1_q;
    end else begin : g_no_out_reg
        assign o_rdata0  = rd0;
        assign o_rdata1  = rd1;
        assign o_rvalid0 = rv0;
        assign o_rvalid1 = rv1;
    end

endmodule

// File: tb/tb_xil_mem_dp_param.sv
// Directed bench: clear timing, byte enables, collisions, forwarding, output pipeline.
module tb_xil_mem_dp_param;

    localparam int unsigned ADR_W = 4;
    localparam int unsigned W     = 36;
    localparam logic [8:0]  INIT_A = 9'h0A5;

    logic clk;
    logic rst_n;

    // dut a: OUT_REG=0, nonzero clear value
    logic         a_ready;
    logic         a_en0, a_en1;
    logic [3:0]   a_wen0, a_wen1;
    logic [3:0]   a_adr0, a_adr1;
    logic [W-1:0] a_wdata0, a_wdata1, a_rdata0, a_rdata1;
    logic         a_rvalid0, a_rvalid1;

    // dut p: OUT_REG=1, default clear value
    logic         p_ready;
    logic         p_en0, p_en1;
    logic [3:0]   p_wen0, p_wen1;
    logic [3:0]   p_adr0, p_adr1;
    logic [W-1:0] p_wdata0, p_wdata1, p_rdata0, p_rdata1;
    logic         p_rvalid0, p_rvalid1;

    int n_chk;
    int n_pass;

    xil_mem_dp_param #(
        .ADR_W(ADR_W), .BYTES(4), .BYTE_W(9), .OUT_REG(1'b0),
        .INIT_ON_RESET(1'b1), .INIT_VAL(INIT_A)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .o_ready(a_ready),
        .i_en0(a_en0), .i_wen0(a_wen0), .i_adr0(a_adr0), .i_wdata0(a_wdata0),
        .o_rdata0(a_rdata0), .o_rvalid0(a_rvalid0),
        .i_en1(a_en1), .i_wen1(a_wen1), .i_adr1(a_adr1), .i_wdata1(a_wdata1),
        .o_rdata1(a_rdata1), .o_rvalid1(a_rvalid1)
    );

    xil_mem_dp_param #(
        .ADR_W(ADR_W), .BYTES(4), .BYTE_W(9), .OUT_REG(1'b1),
        .INIT_ON_RESET(1'b1), .INIT_VAL(9'h000)
    ) u_dut_p (
        .clk(clk), .rst_n(rst_n), .o_ready(p_ready),
        .i_en0(p_en0), .i_wen0(p_wen0), .i_adr0(p_adr0), .i_wdata0(p_wdata0),
        .o_rdata0(p_rdata0), .o_rvalid0(p_rvalid0),
        .i_en1(p_en1), .i_wen1(p_wen1), .i_adr1(p_adr1), .i_wdata1(p_wdata1),
        .o_rdata1(p_rdata1), .o_rvalid1(p_rvalid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [8:0] v);
        return {v, v, v, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from reset release until ready, with port 0 pulsing.
    task automatic wait_ready(output int cyc, output logic rv_seen);
        cyc     = 0;
        rv_seen = 1'b0;
        a_en0   = 1'b1;
        a_adr0  = 4'd0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (a_rvalid0) rv_seen = 1'b1;
            if (a_ready) begin
                cyc = c;
                break;
            end
        end
        a_en0 = 1'b0;
    endtask

    int         cyc;
    logic       rv_seen;
    int         nvalid;
    logic [W-1:0] last;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        {a_en0, a_en1, a_wen0, a_wen1, a_adr0, a_adr1, a_wdata0, a_wdata1} = '0;
        {p_en0, p_en1, p_wen0, p_wen1, p_adr0, p_adr1, p_wdata0, p_wdata1} = '0;

        repeat (3) step();
        chk("rst_ready", W'(a_ready), W'(0));
        chk("rst_rvalid0", W'(a_rvalid0), W'(0));
        chk("rst_rdata0", a_rdata0, '0);

        rst_n = 1'b1;
        wait_ready(cyc, rv_seen);
        chk("clr_cycles", W'(cyc), W'(16));
        chk("rvalid_before_ready", W'(rv_seen), W'(0));
        chk("p_ready", W'(p_ready), W'(1));

        // every word holds the clear value
        a_en0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_adr0 = 4'(i);
            step();
            chk($sformatf("init_rd%0d", i), a_rdata0, rep(INIT_A));
        end
        chk("init_rvalid", W'(a_rvalid0), W'(1));

        a_adr0 = 4'd3; a_wen0 = 4'hF; a_wdata0 = rep(9'h1FF);
        step();
        a_en0 = 1'b0; a_wen0 = 4'h0;
        chk("pre_rst_wr", a_rdata0, rep(9'h1FF));

        // async reset clears outputs without a clock edge
        rst_n = 1'b0;
        #1;
        chk("async_rst_rdata0", a_rdata0, '0);
        step();
        rst_n = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        chk("mid_clr_ready", W'(a_ready), W'(0));
        chk("mid_clr_rdata0", a_rdata0, '0);
        step();
        rst_n = 1'b1;
        wait_ready(cyc, rv_seen);
        chk("reclr_cycles", W'(cyc), W'(16));

        a_en0 = 1'b1; a_adr0 = 4'd3;
        step();
        chk("reclr_addr3", a_rdata0, rep(INIT_A));

        // byte-enable writes, write-first return
        a_wen0 = 4'hF; a_wdata0 = rep(9'h1FF);
        step();
        chk("be_wr_full", a_rdata0, rep(9'h1FF));
        a_wen0 = 4'b0101; a_wdata0 = {9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
        step();
        chk("be_wr_part", a_rdata0, {9'h1FF, 9'h0BB, 9'h1FF, 9'h0DD});
        a_wen0 = 4'h0;
        step();
        chk("be_rd", a_rdata0, {9'h1FF, 9'h0BB, 9'h1FF, 9'h0DD});

        // idle slot: data holds, valid drops
        a_en0 = 1'b0;
        step();
        chk("hold_rvalid", W'(a_rvalid0), W'(0));
        chk("hold_rdata", a_rdata0, {9'h1FF, 9'h0BB, 9'h1FF, 9'h0DD});

        // same-address collision at 5
        a_en0 = 1'b1; a_en1 = 1'b1; a_adr0 = 4'd5; a_adr1 = 4'd5;
        a_wen0 = 4'b0011; a_wdata0 = rep(9'h011);
        a_wen1 = 4'b0110; a_wdata1 = rep(9'h022);
        step();
        chk("coll_rd0", a_rdata0, {INIT_A, 9'h022, 9'h011, 9'h011});
        chk("coll_rd1", a_rdata1, {INIT_A, 9'h022, 9'h011, 9'h011});
        chk("coll_rv1", W'(a_rvalid1), W'(1));
        a_en0 = 1'b0; a_wen0 = 4'h0; a_wen1 = 4'h0;
        step();
        chk("coll_stored", a_rdata1, {INIT_A, 9'h022, 9'h011, 9'h011});

        // port 1 reads while port 0 writes the same address
        a_en0 = 1'b1; a_adr0 = 4'd9; a_wen0 = 4'hF; a_wdata0 = rep(9'h123);
        a_en1 = 1'b1; a_adr1 = 4'd9; a_wen1 = 4'h0;
        step();
        chk("fwd_rd1", a_rdata1, rep(9'h123));
        chk("fwd_rd0", a_rdata0, rep(9'h123));

        // independent writes to different addresses
        a_adr0 = 4'd10; a_wen0 = 4'b1000; a_wdata0 = rep(9'h0C3);
        a_adr1 = 4'd11; a_wen1 = 4'b0001; a_wdata1 = rep(9'h13C);
        step();
        chk("ind_wr0", a_rdata0, {9'h0C3, INIT_A, INIT_A, INIT_A});
        chk("ind_wr1", a_rdata1, {INIT_A, INIT_A, INIT_A, 9'h13C});
        a_wen0 = 4'h0; a_wen1 = 4'h0; a_adr0 = 4'd11; a_adr1 = 4'd10;
        step();
        chk("ind_rd0", a_rdata0, {INIT_A, INIT_A, INIT_A, 9'h13C});
        chk("ind_rd1", a_rdata1, {9'h0C3, INIT_A, INIT_A, INIT_A});
        a_en0 = 1'b0; a_en1 = 1'b0;

        // OUT_REG=1: fill 0..7 through port 1, then stream reads on port 0
        p_en1 = 1'b1; p_wen1 = 4'hF;
        for (int i = 0; i < 8; i++) begin
            p_adr1 = 4'(i);
            p_wdata1 = rep(9'(16 * i + 3));
            step();
        end
        p_en1 = 1'b0; p_wen1 = 4'h0;
        repeat (3) step();

        nvalid = 0;
        for (int t = 0; t < 12; t++) begin
            p_en0  = (t < 8);
            p_adr0 = 4'(t);
            step();
            if (t == 0) chk("pipe_lat_not1", W'(p_rvalid0), W'(0));
            if (t >= 1 && t <= 8) begin
                chk($sformatf("pipe_rd%0d", t - 1), p_rdata0, rep(9'(16 * (t - 1) + 3)));
            end
            if (p_rvalid0) nvalid++;
        end
        p_en0 = 1'b0;
        chk("pipe_nvalid", W'(nvalid), W'(8));
        chk("pipe_hold", p_rdata0, rep(9'(16 * 7 + 3)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
